// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes and active-low seven-segment patterns.
package keypad_pkg;

  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_BS   = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low, dp held off; element d is the glyph for digit d
  localparam logic [9:0][7:0] SEG_LUT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes render blank.
module bcd_to_seg
  import keypad_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_LUT[bcd_i];
  end

endmodule

// File: rtl/key_entry_display.sv
// Keypad event consumer: 8-digit BCD entry buffer with clear/backspace/commit,
// driving a multiplexed 8-digit seven-segment display.
module key_entry_display
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_data,
  input  logic        key_valid,
  output logic [7:0]  led_en,
  output logic [7:0]  led_seg,
  output logic [31:0] value,
  output logic        commit,
  output logic [3:0]  digit_cnt
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic          valid_q;
  logic [31:0]   buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   value_q, value_d;
  logic          commit_q, commit_d;
  logic [CW-1:0] scan_cnt_q;
  logic [2:0]    scan_idx_q;
  logic [7:0]    led_en_q, led_seg_q;
  logic [3:0]    nibble;
  logic [7:0]    seg_w;
  logic          key_event;

  assign key_event = key_valid && !valid_q;

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    commit_d = 1'b0;
    if (key_event) begin
      if (key_data <= 4'd9) begin
        if (cnt_q < 4'd8) begin
          buf_d = {buf_q[27:0], key_data};
          cnt_d = cnt_q + 4'd1;
        end
      end else if (key_data == KEY_CLR) begin
        buf_d = '0;
        cnt_d = '0;
      end else if (key_data == KEY_BS) begin
        if (cnt_q != 4'd0) begin
          buf_d = {4'h0, buf_q[31:4]};
          cnt_d = cnt_q - 4'd1;
        end
      end else if (key_data == KEY_HASH) begin
        value_d  = buf_q;
        commit_d = 1'b1;
        buf_d    = '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      buf_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      valid_q  <= key_valid;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      commit_q <= commit_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      scan_idx_q <= scan_idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  assign nibble = buf_q[{scan_idx_q, 2'b00} +: 4];

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (nibble),
    .seg_o (seg_w)
  );

  // Enable and segments are registered together so digits switch without ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_en_q  <= 8'hFF;
      led_seg_q <= SEG_BLANK;
    end else if ({1'b0, scan_idx_q} < cnt_q) begin
      led_en_q  <= ~(8'h01 << scan_idx_q);
      led_seg_q <= seg_w;
    end else begin
      led_en_q  <= 8'hFF;
      led_seg_q <= SEG_BLANK;
    end
  end

  assign led_en    = led_en_q;
  assign led_seg   = led_seg_q;
  assign value     = value_q;
  assign commit    = commit_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_key_entry_display.sv
// Directed bench for key_entry_display with a short scan divider.
module tb_key_entry_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_data = 4'h0;
  logic        key_valid = 1'b0;
  logic [7:0]  led_en, led_seg;
  logic [31:0] value;
  logic        commit;
  logic [3:0]  digit_cnt;

  int errors = 0;
  int checks = 0;

  key_entry_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_data  (key_data),
    .key_valid (key_valid),
    .led_en    (led_en),
    .led_seg   (led_seg),
    .value     (value),
    .commit    (commit),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_data  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  // Press F and count commit pulses over the following cycles.
  task automatic commit_key(output int pulses);
    pulses = 0;
    @(negedge clk);
    key_data  = 4'hF;
    key_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (commit) pulses++;
    end
  endtask

  task automatic wait_en(input logic [7:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (led_en == want) ok = 1'b1;
    end
  endtask

  initial begin
    int  p;
    bit  ok;
    logic [7:0] exp_en  [8];
    logic [7:0] exp_seg [3];

    repeat (3) @(negedge clk);
    check("reset_led_en", led_en, 8'hFF);
    check("reset_led_seg", led_seg, 8'hFF);
    check("reset_value", value, 0);
    check("reset_commit", commit, 0);
    check("reset_digit_cnt", digit_cnt, 0);
    rst_n = 1'b1;

    // Entry and commit
    press(4'd1); press(4'd2); press(4'd3);
    check("entry_cnt", digit_cnt, 3);
    commit_key(p);
    check("commit_pulses", p, 1);
    check("commit_value", value, 32'h123);
    check("commit_cnt_clear", digit_cnt, 0);

    // Reset mid-entry
    press(4'd7); press(4'd8); press(4'd9);
    check("pre_reset_cnt", digit_cnt, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cnt", digit_cnt, 0);
    check("rst_mid_led_en", led_en, 8'hFF);
    check("rst_mid_value", value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_no_event", digit_cnt, 0);

    // Full buffer, ninth digit ignored
    for (int k = 1; k <= 9; k++) press(4'(k));
    check("full_cnt", digit_cnt, 8);
    commit_key(p);
    check("full_value", value, 32'h12345678);

    // Backspace from full
    for (int k = 1; k <= 9; k++) press(4'(k));
    press(4'hD);
    check("bs_cnt", digit_cnt, 7);
    commit_key(p);
    check("bs_value", value, 32'h01234567);

    // Backspace on empty buffer, then empty commit loads zero
    press(4'hD);
    check("bs_empty_cnt", digit_cnt, 0);
    commit_key(p);
    check("empty_commit_pulses", p, 1);
    check("empty_commit_value", value, 0);

    // Held valid gives one event
    @(negedge clk);
    key_data  = 4'd5;
    key_valid = 1'b1;
    repeat (100) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check("held_cnt", digit_cnt, 1);
    commit_key(p);
    check("held_value", value, 32'h5);

    // Ignored keys and clear
    press(4'd4); press(4'hA); press(4'hB); press(4'hE); press(4'd7);
    check("ignored_cnt", digit_cnt, 2);
    commit_key(p);
    check("ignored_value", value, 32'h47);
    press(4'd4); press(4'hA); press(4'hB); press(4'hE); press(4'd7);
    press(4'hC);
    check("clear_cnt", digit_cnt, 0);
    check("clear_value_kept", value, 32'h47);
    repeat (40) @(negedge clk);
    check("empty_dark", led_en, 8'hFF);

    // Scan of entry 0x305 with SCAN_DIV=4
    press(4'd3); press(4'd0); press(4'd5);
    exp_en  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_seg = '{8'h92, 8'hC0, 8'hB0};
    wait_en(8'hFF, ok);
    check("scan_sync_blank", ok, 1);
    wait_en(8'hFE, ok);
    check("scan_sync_first", ok, 1);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("scan_en_%0d", s), led_en, exp_en[s]);
      if (s < 3) check($sformatf("scan_seg_%0d", s), led_seg, exp_seg[s]);
      repeat (4) @(negedge clk);
    end
    check("scan_wrap_en", led_en, 8'hFE);
    check("scan_wrap_seg", led_seg, 8'h92);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_entry_display.md
# key_entry_display

Consumer of the 4x4 keypad scanner's `data`/`valid` output. Turns accepted key events into an 8-digit decimal entry buffer with clear, backspace and commit, and drives the board's 8-digit multiplexed seven-segment display with the current entry. Sits between the keypad scanner and the seven-segment pins. It is the reader of the scanner's key-code interface.

## Interface
- `SCAN_DIV`, 25000: clk cycles each digit stays lit (1 ms at 25 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_data`  in  4  key code from the scanner. 0-9 are digits, A/B are unused, C is clear, D is backspace, E (`*`) is unused, F (`#`) is commit.
- `key_valid`  in  1  scanner valid, level. Its rising edge marks one key event.
- `led_en`  out  8  digit enables, active-low. Bit 0 is the rightmost digit.
- `led_seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low. dp is always off.
- `value`  out  32  last committed entry: 8 BCD nibbles, nibble 0 = least-significant digit.
- `commit`  out  1  one-cycle pulse when `value` updates.
- `digit_cnt`  out  4  number of digits currently in the entry buffer (0-8).

## Operation
- **Edge detect**
  - `valid_d` registers `key_valid`.
  - An event occurs on a posedge where `key_valid`=1 and `valid_d`=0.
  - `key_data` is sampled on that same posedge.
  - A held `key_valid` produces exactly one event.
- **Digit key (0-9)**
  - If `digit_cnt`<8: `buf` <= {buf[27:0], key}, and `digit_cnt` increments.
  - If `digit_cnt`==8: the key is ignored and nothing changes.
- **C (clear)**: `buf` <= 0 and `digit_cnt` <= 0. `value` is untouched.
- **D (backspace)**
  - If `digit_cnt`>0: `buf` <= {4'h0, buf[31:4]}, and `digit_cnt` decrements.
  - If `digit_cnt`==0: no effect.
- **F (commit)**
  - `value` <= `buf` and `commit` <= 1 for one cycle.
  - `buf` and `digit_cnt` then clear.
  - A commit with `digit_cnt`==0 still fires and loads 0.
- **A, B, E**: ignored.
- **Display scan**
  - A counter runs from 0 to `SCAN_DIV`-1.
  - On wrap, `scan_idx` (3 bit) increments; it wraps from 7 to 0.
  - Digit `scan_idx` shows `buf[4*scan_idx+3 : 4*scan_idx]`.
  - Enable is `led_en` = ~(8'b1 << `scan_idx`) when `scan_idx` < `digit_cnt`.
  - Otherwise `led_en`=8'hFF (blank). An empty buffer shows all digits dark.
  - Leading-digit blanking comes from `digit_cnt` only; zero digits inside the entry are shown.
- **Reset values**
  - Outputs: `led_en`=8'hFF, `led_seg`=8'hFF, `value`=0, `commit`=0, `digit_cnt`=0.
  - Internal state: `buf`=0, `valid_d`=0, `scan_idx`=0, scan counter=0.
- Reset asserted mid-entry or mid-scan clears everything immediately. There is no pending event after release.

## Timing
- **Key path**
  - Event at posedge N: `buf`/`digit_cnt` show the new value after edge N.
  - `commit` is high during cycle N..N+1 only.
  - `value` is valid from the same edge and holds until the next commit.
- **Minimum event spacing**
  - Two cycles: `key_valid` must drop for ≥1 sampled cycle before the next event.
  - The scanner guarantees far more, so no input buffering is needed.
- **Display path**
  - `led_en`/`led_seg` are registered and update one cycle after `scan_idx` changes.
  - They also update one cycle after `buf`/`digit_cnt` change.
  - Refresh period is 8×`SCAN_DIV` cycles.
  - Both outputs switch on the same edge, so there is no ghosting between digits.
- **Simultaneous events**: scan wrap and key event on the same edge are independent. The display reflects the new buffer one cycle later.

## Structure
- **Shared package `keypad_pkg`**
  - Key code constants: `KEY_CLR`=4'hC, `KEY_BS`=4'hD, `KEY_STAR`=4'hE, `KEY_HASH`=4'hF.
  - Active-low segment patterns for 0-9.
  - `SEG_BLANK`=8'hFF.
- **Sub-module `bcd_to_seg`**
  - Combinational, 4-bit in, 8-bit out.
  - Codes above 9 produce `SEG_BLANK`.
- **Top-level contents**: edge detector, entry FSM/datapath, scan counter and output registers.

## Test plan
- **Reset**: check reset values. Assert `rst_n`=0 after entering 3 digits → `digit_cnt`=0, `led_en`=8'hFF, `value`=0.
- **Entry and commit**
  - Stimulus: keys 1,2,3 then F.
  - Before F: `digit_cnt`=3 and `buf`=0x00000123.
  - After F: `value`=0x00000123, a single `commit` pulse, `digit_cnt`=0.
- **Full buffer and backspace**
  - Stimulus: 9 digits 1..9. The 9th is ignored, leaving `buf`=0x12345678 and `digit_cnt`=8.
  - Then D → `buf`=0x01234567, `digit_cnt`=7.
  - D on an empty buffer → no change.
- **Held valid**: `key_valid` held high for 100 cycles with `key_data`=5 → exactly one digit is entered.
- **Clear and ignored keys**
  - Keys 4,A,B,E,7 → `buf`=0x47, `digit_cnt`=2.
  - Then C → `digit_cnt`=0 and `value` is unchanged.
- **Scan**
  - Setup: `SCAN_DIV`=4, entry 0x305.
  - `led_en` cycles FE, FD, FB every 4 cycles with segments '5', '0', '3'.
  - Then FF for indices 3-7, then back to FE.
